// File: rtl/vec_pkg.sv
// Shared definitions for the multi-cycle vector unit: opcodes, FSM states
// and the element-count clamp.
package vec_pkg;

   localparam logic [2:0] VOP_ADD = 3'b000;
   localparam logic [2:0] VOP_SUB = 3'b001;
   localparam logic [2:0] VOP_AND = 3'b010;
   localparam logic [2:0] VOP_OR  = 3'b011;
   localparam logic [2:0] VOP_XOR = 3'b100;
   localparam logic [2:0] VOP_MIN = 3'b101;
   localparam logic [2:0] VOP_MAX = 3'b110;
   localparam logic [2:0] VOP_MOV = 3'b111;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      DONE = 2'd2
   } vstate_t;

   // Requested lengths beyond the register length run the full register.
   function automatic int clamp_vlen(input int len, input int maxlen);
      return (len > maxlen) ? maxlen : len;
   endfunction

endpackage

// File: rtl/vec_lane.sv
// Single-element combinational ALU; one copy per lane of the vector unit.
module vec_lane
   import vec_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] y,
   output logic             is_zero
);

   logic a_lt_b;

   assign a_lt_b = $signed(a) < $signed(b);

   always_comb begin
      y = '0;
      case (op)
         VOP_ADD: y = a + b;
         VOP_SUB: y = a - b;
         VOP_AND: y = a & b;
         VOP_OR:  y = a | b;
         VOP_XOR: y = a ^ b;
         VOP_MIN: y = a_lt_b ? a : b;
         VOP_MAX: y = a_lt_b ? b : a;
         VOP_MOV: y = a;
      endcase
   end

   assign is_zero = (y == '0);

endmodule

// File: rtl/vec_seq_unit.sv
// Multi-cycle vector execution unit: private register file, LANES elements
// per cycle, start/busy/done issue handshake and a registered host read port.
module vec_seq_unit
   import vec_pkg::*;
#(
   parameter  int WIDTH  = 32,
   parameter  int LANES  = 2,
   parameter  int NVREG  = 16,
   parameter  int MAXLEN = 8,
   localparam int RW     = $clog2(NVREG),
   localparam int IW     = $clog2(MAXLEN)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [RW-1:0]    vd,
   input  logic [RW-1:0]    va,
   input  logic [RW-1:0]    vb,
   input  logic [IW:0]      vlen,
   input  logic             wr_en,
   input  logic [RW-1:0]    wr_reg,
   input  logic [IW-1:0]    wr_idx,
   input  logic [WIDTH-1:0] wr_data,
   input  logic [RW-1:0]    rd_reg,
   input  logic [IW-1:0]    rd_idx,
   output logic [WIDTH-1:0] rd_data,
   output logic             busy,
   output logic             done,
   output logic             zflag
);

   localparam int LW = IW + 1;
   localparam int CW = IW + 2;

   // Handshake: start is sampled only in IDLE; busy is high for every EXEC
   // cycle; done pulses for the single DONE cycle, after which start is
   // accepted again. start outside IDLE is dropped, never queued.
   vstate_t state;
   vstate_t state_next;

   logic [WIDTH-1:0] vreg [NVREG][MAXLEN];

   logic [2:0]    op_q;
   logic [RW-1:0] vd_q;
   logic [RW-1:0] va_q;
   logic [RW-1:0] vb_q;
   logic [LW-1:0] vlen_q;
   logic [CW-1:0] eidx;
   logic          zacc;

   logic [LW-1:0] vlen_clamped;
   logic          exec_last;
   logic          grp_zero;

   logic [CW-1:0]    lane_e    [LANES];
   logic             lane_en   [LANES];
   logic [WIDTH-1:0] lane_a    [LANES];
   logic [WIDTH-1:0] lane_b    [LANES];
   logic [WIDTH-1:0] lane_y    [LANES];
   logic             lane_zero [LANES];

   assign vlen_clamped = LW'(clamp_vlen(int'(vlen), MAXLEN));
   assign exec_last    = (eidx + CW'(LANES)) >= CW'(vlen_q);
   assign busy         = (state == EXEC);
   assign done         = (state == DONE);

   // Lanes read the pre-edge register contents, so aliased vd/va/vb behave
   // exactly like distinct registers.
   always_comb begin
      grp_zero = 1'b1;
      for (int l = 0; l < LANES; l++) begin
         lane_e[l]  = eidx + CW'(l);
         lane_en[l] = (state == EXEC) && (lane_e[l] < CW'(vlen_q));
         lane_a[l]  = vreg[va_q][lane_e[l][IW-1:0]];
         lane_b[l]  = vreg[vb_q][lane_e[l][IW-1:0]];
         if (lane_en[l] && !lane_zero[l]) grp_zero = 1'b0;
      end
   end

   for (genvar g = 0; g < LANES; g++) begin : g_lane
      vec_lane #(.WIDTH(WIDTH)) u_lane (
         .op      (op_q),
         .a       (lane_a[g]),
         .b       (lane_b[g]),
         .y       (lane_y[g]),
         .is_zero (lane_zero[g])
      );
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (start) state_next = (vlen_clamped == '0) ? DONE : EXEC;
         EXEC: if (exec_last) state_next = DONE;
         DONE: state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         op_q    <= '0;
         vd_q    <= '0;
         va_q    <= '0;
         vb_q    <= '0;
         vlen_q  <= '0;
         eidx    <= '0;
         zacc    <= 1'b0;
         zflag   <= 1'b0;
         rd_data <= '0;
         for (int r = 0; r < NVREG; r++)
            for (int i = 0; i < MAXLEN; i++)
               vreg[r][i] <= '0;
      end else begin
         state   <= state_next;
         rd_data <= vreg[rd_reg][rd_idx];

         if (wr_en && state != EXEC)
            vreg[wr_reg][wr_idx] <= wr_data;

         case (state)
            IDLE: begin
               if (start) begin
                  op_q   <= op;
                  vd_q   <= vd;
                  va_q   <= va;
                  vb_q   <= vb;
                  vlen_q <= vlen_clamped;
                  eidx   <= '0;
                  zacc   <= 1'b1;
                  if (vlen_clamped == '0) zflag <= 1'b1;
               end
            end
            EXEC: begin
               for (int l = 0; l < LANES; l++)
                  if (lane_en[l])
                     vreg[vd_q][lane_e[l][IW-1:0]] <= lane_y[l];
               eidx <= eidx + CW'(LANES);
               zacc <= zacc & grp_zero;
               // Publish the flag together with the done pulse.
               if (exec_last) zflag <= zacc & grp_zero;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_vec_seq_unit.sv
// Self-checking bench for vec_seq_unit: a reference register-file model
// supplies expected read data through a scoreboard queue.
module tb_vec_seq_unit;

   localparam int WIDTH  = 32;
   localparam int LANES  = 2;
   localparam int NVREG  = 16;
   localparam int MAXLEN = 8;

   logic             clk = 1'b0;
   logic             reset;
   logic             start;
   logic [2:0]       op;
   logic [3:0]       vd, va, vb;
   logic [3:0]       vlen;
   logic             wr_en;
   logic [3:0]       wr_reg;
   logic [2:0]       wr_idx;
   logic [WIDTH-1:0] wr_data;
   logic [3:0]       rd_reg;
   logic [2:0]       rd_idx;
   logic [WIDTH-1:0] rd_data;
   logic             busy, done, zflag;

   logic [WIDTH-1:0] exp_q[$];
   logic [WIDTH-1:0] mem [NVREG][MAXLEN];
   int n_vec  = 0;
   int n_miss = 0;

   vec_seq_unit #(.WIDTH(WIDTH), .LANES(LANES), .NVREG(NVREG), .MAXLEN(MAXLEN)) dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .op      (op),
      .vd      (vd),
      .va      (va),
      .vb      (vb),
      .vlen    (vlen),
      .wr_en   (wr_en),
      .wr_reg  (wr_reg),
      .wr_idx  (wr_idx),
      .wr_data (wr_data),
      .rd_reg  (rd_reg),
      .rd_idx  (rd_idx),
      .rd_data (rd_data),
      .busy    (busy),
      .done    (done),
      .zflag   (zflag)
   );

   always #5 clk = ~clk;

   function automatic logic [WIDTH-1:0] mop(input logic [2:0] o, input logic [WIDTH-1:0] a,
                                            input logic [WIDTH-1:0] b);
      case (o)
         3'd0: return a + b;
         3'd1: return a - b;
         3'd2: return a & b;
         3'd3: return a | b;
         3'd4: return a ^ b;
         3'd5: return ($signed(a) < $signed(b)) ? a : b;
         3'd6: return ($signed(a) > $signed(b)) ? a : b;
         default: return a;
      endcase
   endfunction

   task automatic host_write(input int r, input int i, input logic [WIDTH-1:0] d);
      @(negedge clk);
      wr_en = 1'b1; wr_reg = 4'(r); wr_idx = 3'(i); wr_data = d;
      @(negedge clk);
      wr_en = 1'b0;
      mem[r][i] = d;
   endtask

   task automatic check_reg(input int r, input string tag);
      logic [WIDTH-1:0] e;
      for (int i = 0; i < MAXLEN; i++) begin
         @(negedge clk);
         rd_reg = 4'(r); rd_idx = 3'(i);
         exp_q.push_back(mem[r][i]);
         @(negedge clk);
         e = exp_q.pop_front();
         n_vec++;
         if (rd_data !== e) begin
            n_miss++;
            $display("FAIL %s V%0d[%0d]: got %h want %h", tag, r, i, rd_data, e);
         end
      end
   endtask

   task automatic run_op(input logic [2:0] o, input int d, input int a, input int b,
                         input int len, input string tag);
      logic [WIDTH-1:0] res [MAXLEN];
      logic ez;
      int n, cyc, bcnt, exp_cyc;
      n  = (len > MAXLEN) ? MAXLEN : len;
      ez = 1'b1;
      for (int i = 0; i < n; i++) begin
         res[i] = mop(o, mem[a][i], mem[b][i]);
         if (res[i] != '0) ez = 1'b0;
      end
      exp_cyc = (n + LANES - 1) / LANES + 1;
      @(negedge clk);
      start = 1'b1; op = o; vd = 4'(d); va = 4'(a); vb = 4'(b); vlen = 4'(len);
      @(negedge clk);
      start = 1'b0; cyc = 1; bcnt = 0;
      while (!done && cyc < 64) begin
         if (busy) bcnt++;
         @(negedge clk);
         cyc++;
      end
      n_vec++;
      if (done !== 1'b1) begin n_miss++; $display("FAIL %s timeout: done=%b want 1", tag, done); end
      n_vec++;
      if (cyc != exp_cyc) begin n_miss++; $display("FAIL %s latency: got %0d want %0d", tag, cyc, exp_cyc); end
      n_vec++;
      if (bcnt != exp_cyc - 1) begin n_miss++; $display("FAIL %s busy_cycles: got %0d want %0d", tag, bcnt, exp_cyc - 1); end
      n_vec++;
      if (busy !== 1'b0) begin n_miss++; $display("FAIL %s busy_at_done: got %b want 0", tag, busy); end
      n_vec++;
      if (zflag !== ez) begin n_miss++; $display("FAIL %s zflag: got %b want %b", tag, zflag, ez); end
      for (int i = 0; i < n; i++) mem[d][i] = res[i];
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(negedge clk);
      n_vec++;
      if ({busy, done, zflag} !== 3'b000) begin
         n_miss++; $display("FAIL reset_outputs: got %b want 000", {busy, done, zflag});
      end
      n_vec++;
      if (rd_data !== '0) begin n_miss++; $display("FAIL reset_rd_data: got %h want 0", rd_data); end
      reset = 1'b0;
      check_reg(0, "reset_v0");
   endtask

   task automatic test_add();
      for (int i = 0; i < MAXLEN; i++) begin
         host_write(1, i, WIDTH'(i + 1));
         host_write(2, i, WIDTH'(10 * (i + 1)));
      end
      run_op(3'd0, 3, 1, 2, 8, "add");
      check_reg(3, "add_v3");
   endtask

   task automatic test_wrap();
      for (int i = 0; i < MAXLEN; i++) begin
         host_write(1, i, 32'hFFFF_FFFF);
         host_write(2, i, 32'd1);
      end
      run_op(3'd0, 3, 1, 2, 3, "wrap");
      check_reg(3, "wrap_v3");
   endtask

   task automatic test_min_alias();
      logic [WIDTH-1:0] av [4];
      logic [WIDTH-1:0] bv [4];
      av = '{-32'sd5, 32'sd7, 32'sd0, -32'sd1};
      bv = '{32'sd3, -32'sd9, 32'sd0, -32'sd2};
      for (int i = 0; i < 4; i++) begin
         host_write(4, i, av[i]);
         host_write(5, i, bv[i]);
      end
      run_op(3'd5, 4, 4, 5, 4, "min_alias");
      check_reg(4, "min_alias_v4");
   endtask

   task automatic test_vlen_edges();
      run_op(3'd0, 6, 1, 2, 0, "vlen0");
      check_reg(6, "vlen0_v6");
      run_op(3'd1, 6, 2, 4, 12, "vlen12");
      check_reg(6, "vlen12_v6");
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < MAXLEN; i++) begin
         host_write(8, i, WIDTH'($urandom()));
         host_write(9, i, WIDTH'($urandom()));
      end
      host_write(8, 0, 32'h8000_0000);
      host_write(9, 0, 32'h7FFF_FFFF);
      for (int k = 1; k < 7; k++)
         run_op(3'(k), 10 + k - 1, 8, 9, $urandom_range(1, MAXLEN), "b2b");
      for (int k = 1; k < 7; k++) check_reg(10 + k - 1, "b2b_dst");
   endtask

   task automatic test_blocked();
      logic [WIDTH-1:0] prior;
      int cyc;
      prior = mem[1][0];
      @(negedge clk);
      start = 1'b1; op = 3'd7; vd = 4'd7; va = 4'd2; vb = 4'd0; vlen = 4'd8;
      @(negedge clk);
      start = 1'b0; cyc = 1;
      @(negedge clk);
      cyc = 2;
      start = 1'b1; op = 3'd0; vd = 4'd1; va = 4'd1; vb = 4'd1; vlen = 4'd8;
      wr_en = 1'b1; wr_reg = 4'd1; wr_idx = 3'd0; wr_data = 32'hAA;
      @(negedge clk);
      cyc = 3;
      start = 1'b0; wr_en = 1'b0;
      while (!done && cyc < 64) begin @(negedge clk); cyc++; end
      n_vec++;
      if (cyc != 5) begin n_miss++; $display("FAIL blocked_latency: got %0d want 5", cyc); end
      for (int i = 0; i < MAXLEN; i++) mem[7][i] = mem[2][i];
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         n_vec++;
         if (done !== 1'b0 || busy !== 1'b0) begin
            n_miss++; $display("FAIL blocked_no_requeue: busy=%b done=%b want 0 0", busy, done);
         end
      end
      n_vec++;
      if (mem[1][0] !== prior) begin n_miss++; $display("FAIL blocked_model: got %h want %h", mem[1][0], prior); end
      check_reg(1, "blocked_v1");
      check_reg(7, "blocked_v7");
   endtask

   task automatic test_reset_mid();
      int quiet;
      @(negedge clk);
      start = 1'b1; op = 3'd0; vd = 4'd3; va = 4'd1; vb = 4'd2; vlen = 4'd8;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      n_vec++;
      if ({busy, done, zflag} !== 3'b000) begin
         n_miss++; $display("FAIL reset_mid_outputs: got %b want 000", {busy, done, zflag});
      end
      quiet = 1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (done !== 1'b0 || busy !== 1'b0) quiet = 0;
      end
      n_vec++;
      if (quiet != 1) begin n_miss++; $display("FAIL reset_mid_no_done: got %0d want 1", quiet); end
      for (int r = 0; r < NVREG; r++)
         for (int i = 0; i < MAXLEN; i++) mem[r][i] = '0;
      for (int r = 0; r < NVREG; r++) check_reg(r, "reset_mid_clear");
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; op = '0; vd = '0; va = '0; vb = '0; vlen = '0;
      wr_en = 1'b0; wr_reg = '0; wr_idx = '0; wr_data = '0; rd_reg = '0; rd_idx = '0;
      for (int r = 0; r < NVREG; r++)
         for (int i = 0; i < MAXLEN; i++) mem[r][i] = '0;
      test_reset();
      test_add();
      test_wrap();
      test_min_alias();
      test_vlen_edges();
      test_back_to_back();
      test_blocked();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
